booth_mult_seq: RTL and testbench

- Parametrised, iterative radix-2 Booth multiplier for the arithmetic datapath.
- Retires one multiplier bit per clock.
- Handles signed or unsigned operands, selected per transaction.
- Uses valid/ready handshakes on input and output, so it sits between pipeline stages with backpressure.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_step.sv | 30 +++
 rtl/booth_mult_seq.sv | 126 ++++++++++++
 tb/tb_booth_mult_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier family.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   // Recode key is {Q[0], q_prev}
   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   function automatic logic ext_bit(input logic msb, input logic sgn);
      return sgn & msb;
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode, add/sub M into P, arithmetic shift.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0] p_i,
   input  logic [WIDTH:0] q_i,
   input  logic           qp_i,
   input  logic [WIDTH:0] m_i,
   input  logic [WIDTH:0] m_neg_i,
   output logic [WIDTH:0] p_o,
   output logic [WIDTH:0] q_o,
   output logic           qp_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      unique case ({q_i[0], qp_i})
         BOOTH_ADD: sum = p_i + m_i;
         BOOTH_SUB: sum = p_i + m_neg_i;
         default:   sum = p_i;
      endcase
      p_o  = {sum[WIDTH], sum[WIDTH:1]};
      q_o  = {sum[0], q_i[WIDTH:1]};
      qp_o = q_i[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier with valid/ready handshakes.
// Optional BOOTH_EARLY_TERM_EN: finish early once remaining bits need no adds.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   state_e               state_q;
   logic [WIDTH:0]       p_q, q_q, m_q, mneg_q;
   logic                 qp_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 ov_q;

   logic [WIDTH:0]       a_ext, b_ext;
   logic [WIDTH:0]       sp, sq;
   logic                 sqp;
   logic [WIDTH:0]       p_d, q_d;
   logic                 qp_d;
   logic                 done_d;
   logic [2*WIDTH-1:0]   prod_d;

   assign a_ext = {ext_bit(a[WIDTH-1], signed_mode), a};
   assign b_ext = {ext_bit(b[WIDTH-1], signed_mode), b};

   booth_step #(.WIDTH(WIDTH)) u_step (
      .p_i     (p_q),
      .q_i     (q_q),
      .qp_i    (qp_q),
      .m_i     (m_q),
      .m_neg_i (mneg_q),
      .p_o     (sp),
      .q_o     (sq),
      .qp_o    (sqp)
   );

`ifdef BOOTH_EARLY_TERM_EN
   logic [CNT_W-1:0]         rem;
   logic [WIDTH:0]           keep;
   logic signed [2*WIDTH+2:0] acc;

   // Unconsumed bits after this step sit in sq[rem-1:0]
   always_comb begin
      rem    = CNT_W'(WIDTH) - cnt_q;
      keep   = ~({(WIDTH+1){1'b1}} << rem);
      done_d = ((sq ^ {(WIDTH+1){sqp}}) & keep) == '0;
      acc    = $signed({sp, sq, sqp}) >>> rem;
      p_d    = acc[2*WIDTH+2:WIDTH+2];
      q_d    = acc[WIDTH+1:1];
      qp_d   = acc[0];
   end
`else
   always_comb begin
      done_d = (cnt_q == CNT_W'(WIDTH));
      p_d    = sp;
      q_d    = sq;
      qp_d   = sqp;
   end
`endif

   assign prod_d = {p_d[WIDTH-2:0], q_d};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         q_q     <= '0;
         qp_q    <= 1'b0;
         m_q     <= '0;
         mneg_q  <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         ov_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  m_q     <= a_ext;
                  mneg_q  <= -a_ext;
                  p_q     <= '0;
                  q_q     <= b_ext;
                  qp_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               p_q   <= p_d;
               q_q   <= q_d;
               qp_q  <= qp_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (done_d) begin
                  prod_q  <= prod_d;
                  ov_q    <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  ov_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = ov_q;
   assign product   = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=8 main, WIDTH=64 corner case).
module tb_booth_mult_seq;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid, in_ready, signed_mode;
   logic          out_valid, out_ready;
   logic [W-1:0]  a, b;
   logic [2*W-1:0] product;

   logic          iv64, ir64, sm64, ov64, or64;
   logic [63:0]   a64, b64;
   logic [127:0]  prod64;

   int            total = 0;
   int            bad = 0;
   logic [15:0]   exp_q[$];
   bit            rand_rdy = 1'b0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .product(product)
   );

   booth_mult_seq #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(iv64), .in_ready(ir64),
      .a(a64), .b(b64), .signed_mode(sm64),
      .out_valid(ov64), .out_ready(or64),
      .product(prod64)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_lat(input string nm, input int k, input int full);
`ifdef BOOTH_EARLY_TERM_EN
      chk(nm, 128'(k >= 1 && k <= full), 128'(1));
`else
      chk(nm, 128'(k), 128'(full));
`endif
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input bit s);
      longint px, py;
      logic [63:0] r;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      r  = 64'(px * py);
      return r[15:0];
   endfunction

   // Monitor: every completed output transfer is matched against the queue
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h want none", product);
         end else begin
            chk("product", 128'(product), 128'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y,
                       input bit s, input logic [15:0] e);
      int n = 0;
      @(posedge clk);
      #1;
      a = x;
      b = y;
      signed_mode = s;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got busy want ready");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      signed_mode = 1'($urandom);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 1000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      int k;
      logic [7:0] x, y;
      bit s;
      in_valid = 0; a = 0; b = 0; signed_mode = 0; out_ready = 1;
      iv64 = 0; a64 = 0; b64 = 0; sm64 = 0; or64 = 1;

      #2;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_product", 128'(product), 128'(0));
      @(posedge clk);
      #1 rst = 0;

      send(8'd5, 8'hFD, 1, 16'hFFF1);
      wait_valid(k);
      chk_lat("lat_signed", k, W + 1);
      send(8'hFF, 8'hFF, 0, 16'hFE01);
      send(8'h80, 8'h80, 1, 16'h4000);
      send(8'h80, 8'h7F, 1, 16'hC080);
      send(8'h00, 8'h80, 1, 16'h0000);
      drain();

      @(posedge clk);
      #1 out_ready = 0;
      send(8'h12, 8'h34, 0, 16'h03A8);
      wait_valid(k);
      in_valid = 1'b1;
      a = 8'h01;
      b = 8'h01;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_product", 128'(product), 128'(16'h03A8));
         chk("bp_out_valid", 128'(out_valid), 128'(1));
         chk("bp_in_ready", 128'(in_ready), 128'(0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 128'(in_ready), 128'(1));
      chk("bp_release_out_valid", 128'(out_valid), 128'(0));
      repeat (12) @(negedge clk);
      chk("bp_no_second_op", 128'(out_valid), 128'(0));

      send(8'h55, 8'h66, 0, ref_mul(8'h55, 8'h66, 0));
      repeat (4) @(posedge clk);
      #1 rst = 1;
      exp_q.delete();
      #1;
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_product", 128'(product), 128'(0));
      @(posedge clk);
      #1 rst = 0;
      send(8'd3, 8'd7, 0, 16'h0015);
      wait_valid(k);
      chk_lat("lat_after_rst", k, W + 1);
      drain();

`ifdef BOOTH_EARLY_TERM_EN
      send(8'd9, 8'd1, 1, 16'h0009);
      wait_valid(k);
      chk("et_lat_b1", 128'(k), 128'(2));
      send(8'd9, 8'd0, 1, 16'h0000);
      wait_valid(k);
      chk("et_lat_b0", 128'(k), 128'(1));
      drain();
`endif

      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         s = 1'($urandom);
         send(x, y, s, ref_mul(x, y, s));
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain();

      @(posedge clk);
      #1;
      a64 = 64'h8000_0000_0000_0000;
      b64 = 64'hFFFF_FFFF_FFFF_FFFF;
      sm64 = 1'b1;
      iv64 = 1'b1;
      k = 0;
      @(negedge clk);
      while (!ir64 && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      iv64 = 1'b0;
      a64 = '0;
      b64 = '0;
      k = 0;
      @(negedge clk);
      while (!ov64 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk_lat("lat_w64", k, 65);
      chk("w64_product", prod64,
          128'h0000_0000_0000_0000_8000_0000_0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
